col_addr_skid_buf: RTL and testbench

COL_ADDR_SKID_BUF -- requirements
Module: col_addr_skid_buf

---
 rtl/scu_memshare_pkg.sv | 16 +
 rtl/col_addr_skid_buf.sv | 144 ++++++++++++++
 tb/tb_col_addr_skid_buf.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scu_memshare_pkg.sv
// Shared types and constants for the SCU memShare column-address path.
package scu_memshare_pkg;

    localparam int unsigned COL_ADDR_W = 5;

    // Enumerators are prefixed so they do not clash with the SKID select constant below.
    typedef enum logic [1:0] {
        StPass  = 2'd0,
        StSkid  = 2'd1,
        StDrain = 2'd2
    } skid_buf_state_e;

    localparam logic NOSKID = 1'b0;
    localparam logic SKID   = 1'b1;

endpackage

// File: rtl/col_addr_skid_buf.sv
// Column-address skid buffer between the upstream address source and the shifter.
// Define COL_ADDR_SKID_ERR_CHK_EN to build the over-length skid counter and sticky error.
module col_addr_skid_buf
    import scu_memshare_pkg::*;
#(
    parameter int unsigned ADDR_W            = COL_ADDR_W,
    parameter int unsigned MAX_ALLOC_SEQ_NUM = 2
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] col_addr_i,
    input  logic              col_addr_valid_i,
    output logic              col_addr_ready_o,
    input  logic              isColAddr_skid_i,
    input  logic              pipeCycle_begin_i,
    output logic [ADDR_W-1:0] col_addr_o,
    output logic              col_addr_valid_o,
    input  logic              col_addr_ready_i,
    output logic [1:0]        skid_state_o,
    output logic              skid_err_o
);

    skid_buf_state_e stateQ, stateD;
    logic [ADDR_W-1:0] colAddrQ, colAddrD;
    logic [ADDR_W-1:0] skidRegQ, skidRegD;
    logic colAddrValidQ, colAddrValidD;
    logic skidFullQ, skidFullD;
    logic adv, acc;

    assign adv              = !colAddrValidQ || col_addr_ready_i;
    assign col_addr_ready_o = adv && (stateQ != StDrain);
    assign acc              = col_addr_valid_i && col_addr_ready_o;

    always_comb begin
        stateD        = stateQ;
        colAddrD      = colAddrQ;
        colAddrValidD = colAddrValidQ;
        skidRegD      = skidRegQ;
        skidFullD     = skidFullQ;
        if (adv) begin
            case (stateQ)
                StPass: begin
                    if (acc && ((isColAddr_skid_i == NOSKID) || pipeCycle_begin_i)) begin
                        colAddrD      = col_addr_i;
                        colAddrValidD = 1'b1;
                    end else if (acc) begin
                        // Park the address and emit one bubble.
                        skidRegD      = col_addr_i;
                        skidFullD     = 1'b1;
                        colAddrValidD = 1'b0;
                        stateD        = StSkid;
                    end else begin
                        colAddrValidD = 1'b0;
                    end
                end
                StSkid: begin
                    if ((isColAddr_skid_i == NOSKID) && pipeCycle_begin_i) begin
                        // Pipeline boundary: the parked entry is dropped, input goes straight out.
                        skidFullD     = 1'b0;
                        colAddrValidD = acc;
                        if (acc) begin
                            colAddrD = col_addr_i;
                        end
                        stateD = StPass;
                    end else begin
                        colAddrD      = skidRegQ;
                        colAddrValidD = skidFullQ;
                        skidRegD      = col_addr_i;
                        skidFullD     = acc;
                        if (isColAddr_skid_i == NOSKID) begin
                            stateD = StDrain;
                        end
                    end
                end
                StDrain: begin
                    colAddrD      = skidRegQ;
                    colAddrValidD = skidFullQ;
                    skidFullD     = 1'b0;
                    stateD        = StPass;
                end
                default: begin
                    stateD = StPass;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            stateQ        <= StPass;
            colAddrQ      <= '0;
            colAddrValidQ <= 1'b0;
            skidRegQ      <= '0;
            skidFullQ     <= 1'b0;
        end else begin
            stateQ        <= stateD;
            colAddrQ      <= colAddrD;
            colAddrValidQ <= colAddrValidD;
            skidRegQ      <= skidRegD;
            skidFullQ     <= skidFullD;
        end
    end

    assign col_addr_o       = colAddrQ;
    assign col_addr_valid_o = colAddrValidQ;
    assign skid_state_o     = stateQ;

`ifdef COL_ADDR_SKID_ERR_CHK_EN
    localparam int unsigned CntW = $clog2(MAX_ALLOC_SEQ_NUM + 2);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_ALLOC_SEQ_NUM + 1);

    logic [CntW-1:0] skidCntQ, skidCntD;
    logic skidErrQ, skidErrD;

    always_comb begin
        skidCntD = skidCntQ;
        if (adv && (stateQ == StSkid)) begin
            if (stateD != StSkid) begin
                skidCntD = '0;
            end else if (skidCntQ != CntMax) begin
                skidCntD = skidCntQ + CntW'(1);
            end
        end
        skidErrD = skidErrQ || (skidCntD == CntMax);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            skidCntQ <= '0;
            skidErrQ <= 1'b0;
        end else begin
            skidCntQ <= skidCntD;
            skidErrQ <= skidErrD;
        end
    end

    assign skid_err_o = skidErrQ;
`else
    logic unusedMaxSeq;
    assign unusedMaxSeq = (MAX_ALLOC_SEQ_NUM != 0);
    assign skid_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_col_addr_skid_buf.sv
// Self-checking bench for col_addr_skid_buf: queue-based reference model plus directed cases.
module tb_col_addr_skid_buf;

    localparam int AddrW  = 5;
    localparam int MaxSeq = 2;

    logic sys_clk;
    logic rst;
    logic [AddrW-1:0] col_addr_i;
    logic col_addr_valid_i;
    logic col_addr_ready_o;
    logic isColAddr_skid_i;
    logic pipeCycle_begin_i;
    logic [AddrW-1:0] col_addr_o;
    logic col_addr_valid_o;
    logic col_addr_ready_i;
    logic [1:0] skid_state_o;
    logic skid_err_o;

    col_addr_skid_buf #(
        .ADDR_W           (AddrW),
        .MAX_ALLOC_SEQ_NUM(MaxSeq)
    ) dut (
        .sys_clk          (sys_clk),
        .rst              (rst),
        .col_addr_i       (col_addr_i),
        .col_addr_valid_i (col_addr_valid_i),
        .col_addr_ready_o (col_addr_ready_o),
        .isColAddr_skid_i (isColAddr_skid_i),
        .pipeCycle_begin_i(pipeCycle_begin_i),
        .col_addr_o       (col_addr_o),
        .col_addr_valid_o (col_addr_valid_o),
        .col_addr_ready_i (col_addr_ready_i),
        .skid_state_o     (skid_state_o),
        .skid_err_o       (skid_err_o)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int passCnt = 0;
    int totalCnt = 0;

    task automatic check(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: mode 0/1/2 = pass/skid/drain, parked addresses held in a queue.
    int  mMode;
    bit  mValid;
    int  mAddr;
    int  mQ[$];
    int  mRun;
    bit  mErr;
    bit  mInit = 0;

    always @(posedge sys_clk) begin : model
        bit mAdv;
        bit take;
        int prevMode;
        if (rst) begin
            mMode = 0; mValid = 0; mAddr = 0; mQ.delete(); mRun = 0; mErr = 0; mInit = 1;
        end else if (mInit) begin
            mAdv = !mValid || col_addr_ready_i;
            if (mAdv) begin
                take = col_addr_valid_i && (mMode != 2);
                prevMode = mMode;
                case (mMode)
                    0: begin
                        if (take && isColAddr_skid_i && !pipeCycle_begin_i) begin
                            mQ.push_back(int'(col_addr_i)); mValid = 0; mMode = 1;
                        end else if (take) begin
                            mAddr = int'(col_addr_i); mValid = 1;
                        end else mValid = 0;
                    end
                    1: begin
                        if (!isColAddr_skid_i && pipeCycle_begin_i) begin
                            mQ.delete(); mValid = take;
                            if (take) mAddr = int'(col_addr_i);
                            mMode = 0;
                        end else begin
                            if (mQ.size() > 0) begin mAddr = mQ.pop_front(); mValid = 1; end
                            else mValid = 0;
                            if (take) mQ.push_back(int'(col_addr_i));
                            if (!isColAddr_skid_i) mMode = 2;
                        end
                    end
                    default: begin
                        if (mQ.size() > 0) begin mAddr = mQ.pop_front(); mValid = 1; end
                        else mValid = 0;
                        mMode = 0;
                    end
                endcase
                // Length of the current unbroken skid run, capped one past the limit.
                if (prevMode == 1 && mMode == 1) mRun = (mRun < MaxSeq + 1) ? mRun + 1 : mRun;
                else if (prevMode == 1) mRun = 0;
`ifdef COL_ADDR_SKID_ERR_CHK_EN
                if (mRun == MaxSeq + 1) mErr = 1;
`endif
            end
        end
    end

    int outLog[$];

    always @(negedge sys_clk) begin : compare
        bit expRdy;
        if (mInit && !rst) begin
            expRdy = (!mValid || col_addr_ready_i) && (mMode != 2);
            check("valid_o", int'(col_addr_valid_o), int'(mValid));
            check("ready_o", int'(col_addr_ready_o), int'(expRdy));
            check("state_o", int'(skid_state_o), mMode);
            check("err_o", int'(skid_err_o), int'(mErr));
            if (mValid) check("addr_o", int'(col_addr_o), mAddr);
            if (col_addr_valid_o && col_addr_ready_i) outLog.push_back(int'(col_addr_o));
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Present one address and hold it until the edge at which it is accepted.
    task automatic send(input int addr, input bit skid, input bit beg, output int lowCycles);
        bit rdy;
        int n;
        col_addr_i = AddrW'(addr);
        col_addr_valid_i = 1'b1;
        isColAddr_skid_i = skid;
        pipeCycle_begin_i = beg;
        lowCycles = 0;
        n = 0;
        do begin
            #1;
            rdy = col_addr_ready_o;
            if (!rdy) lowCycles++;
            @(posedge sys_clk);
            #1;
            n++;
        end while (!rdy && n < 20);
        if (!rdy) check("send_timeout", 0, 1);
        col_addr_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        col_addr_valid_i = 1'b0;
        isColAddr_skid_i = 1'b0;
        pipeCycle_begin_i = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic checkLog(input string name, input int exp[$]);
        check({name, "_len"}, outLog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < outLog.size(); i++)
            check(name, outLog[i], exp[i]);
    endtask

    task automatic doReset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin : stim
        int low;
        int lowTot;
        rst = 1'b1;
        col_addr_i = '0;
        col_addr_valid_i = 1'b0;
        isColAddr_skid_i = 1'b0;
        pipeCycle_begin_i = 1'b0;
        col_addr_ready_i = 1'b1;

        doReset();
        check("rst_valid", int'(col_addr_valid_o), 0);
        check("rst_state", int'(skid_state_o), 0);
        check("rst_ready", int'(col_addr_ready_o), 1);
        check("rst_err", int'(skid_err_o), 0);

        // Pass-through with a two-cycle downstream stall.
        outLog.delete();
        send(3, 0, 0, low);
        check("pass_lat_addr", int'(col_addr_o), 3);
        check("pass_lat_valid", int'(col_addr_valid_o), 1);
        send(4, 0, 0, low);
        check("pass_addr4", int'(col_addr_o), 4);
        col_addr_ready_i = 1'b0;
        col_addr_i = 5'd5;
        col_addr_valid_i = 1'b1;
        #1;
        check("stall_ready0", int'(col_addr_ready_o), 0);
        step();
        step();
        check("stall_hold4", int'(col_addr_o), 4);
        check("stall_ready1", int'(col_addr_ready_o), 0);
        col_addr_ready_i = 1'b1;
        send(5, 0, 0, low);
        check("pass_addr5", int'(col_addr_o), 5);
        idle(2);
        checkLog("pass_seq", '{3, 4, 5});

        // Skid entry, run and drain.
        outLog.delete();
        lowTot = 0;
        send(3, 0, 0, low); lowTot += low;
        send(4, 1, 0, low); lowTot += low;
        check("skid_bubble", int'(col_addr_valid_o), 0);
        send(5, 1, 0, low); lowTot += low;
        send(6, 0, 0, low); lowTot += low;
        check("skid_drain_state", int'(skid_state_o), 2);
        send(7, 0, 0, low); lowTot += low;
        check("skid_drain_low", lowTot, 1);
        idle(3);
        checkLog("skid_seq", '{3, 4, 5, 6, 7});
        check("skid_end_state", int'(skid_state_o), 0);

        // Leaving SKID at a pipeline boundary discards the parked entry.
        outLog.delete();
        send(5, 1, 0, low);
        check("bnd_state_skid", int'(skid_state_o), 1);
        send(9, 0, 1, low);
        check("bnd_addr", int'(col_addr_o), 9);
        check("bnd_state_pass", int'(skid_state_o), 0);
        idle(3);
        checkLog("bnd_seq", '{9});

        // skid=1 together with begin=1 in PASS is a plain pass.
        outLog.delete();
        send(8, 1, 1, low);
        check("rule_state", int'(skid_state_o), 0);
        check("rule_addr", int'(col_addr_o), 8);
        check("rule_valid", int'(col_addr_valid_o), 1);
        idle(2);

        // Reset with a parked address drops it.
        outLog.delete();
        send(20, 1, 0, low);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_state", int'(skid_state_o), 0);
        check("mid_rst_valid", int'(col_addr_valid_o), 0);
        idle(3);
        check("mid_rst_lost", outLog.size(), 0);

        // Randomised traffic checked against the model every cycle.
        for (int i = 0; i < 400; i++) begin
            col_addr_i = AddrW'($urandom_range(0, 31));
            col_addr_valid_i = 1'($urandom_range(0, 3) != 0);
            isColAddr_skid_i = 1'($urandom_range(0, 1));
            pipeCycle_begin_i = 1'($urandom_range(0, 3) == 0);
            col_addr_ready_i = 1'($urandom_range(0, 3) != 0);
            rst = 1'($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        col_addr_ready_i = 1'b1;
        doReset();
        idle(1);

        // Over-length skid sequence.
        outLog.delete();
        send(10, 1, 0, low);
        send(11, 1, 0, low);
        send(12, 1, 0, low);
        check("err_before", int'(skid_err_o), 0);
        send(13, 1, 0, low);
`ifdef COL_ADDR_SKID_ERR_CHK_EN
        check("err_set", int'(skid_err_o), 1);
`else
        check("err_off", int'(skid_err_o), 0);
`endif
        send(14, 1, 0, low);
        idle(4);
        checkLog("err_seq", '{10, 11, 12, 13, 14});
`ifdef COL_ADDR_SKID_ERR_CHK_EN
        check("err_sticky", int'(skid_err_o), 1);
`else
        check("err_off_held", int'(skid_err_o), 0);
`endif
        doReset();
        check("err_cleared", int'(skid_err_o), 0);
        check("final_ready", int'(col_addr_ready_o), 1);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
